// File: rtl/axi4_lite_pkg.sv
// Shared AXI4-Lite types and response codes.
// Used by the CSR register slave and its register array.
package axi4_lite_pkg;

  typedef logic [1:0] axi_resp_t;
  typedef logic [2:0] axi_prot_t;

  localparam axi_resp_t AXI_RESP_OKAY   = 2'b00;
  localparam axi_resp_t AXI_RESP_SLVERR = 2'b10;

  // Index width for a bank of n entries (never zero).
  function automatic int unsigned idx_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/axi4_lite_reg_array.sv
// Register bank: byte-strobed write port, combinational
// read port and flat export of all register contents.
module axi4_lite_reg_array
  import axi4_lite_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned NUM_REGS   = 16,
  parameter int unsigned RW         = idx_w(NUM_REGS)
) (
  input  logic                           clk_i,
  input  logic                           rst_n_i,
  input  logic                           we_i,
  input  logic [RW-1:0]                  waddr_i,
  input  logic [DATA_WIDTH-1:0]          wdata_i,
  input  logic [DATA_WIDTH/8-1:0]        wstrb_i,
  input  logic [RW-1:0]                  raddr_i,
  output logic [DATA_WIDTH-1:0]          rdata_o,
  output logic [NUM_REGS*DATA_WIDTH-1:0] regs_o
);

  localparam int unsigned STRB_W = DATA_WIDTH / 8;

  logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];
  logic [DATA_WIDTH-1:0] regs_d [NUM_REGS];

  // Merge strobed bytes of the write into the addressed register.
  always_comb begin
    for (int k = 0; k < NUM_REGS; k++) begin
      regs_d[k] = regs_q[k];
    end
    if (we_i) begin
      for (int b = 0; b < STRB_W; b++) begin
        if (wstrb_i[b]) begin
          regs_d[waddr_i][b*8 +: 8] = wdata_i[b*8 +: 8];
        end
      end
    end
  end

  // Register storage, cleared by reset.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      for (int k = 0; k < NUM_REGS; k++) begin
        regs_q[k] <= '0;
      end
    end else begin
      for (int k = 0; k < NUM_REGS; k++) begin
        regs_q[k] <= regs_d[k];
      end
    end
  end

  assign rdata_o = regs_q[raddr_i];

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_flat
    assign regs_o[g*DATA_WIDTH +: DATA_WIDTH] = regs_q[g];
  end

endmodule

// File: rtl/axi4_lite_reg_slave.sv
// AXI4-Lite CSR slave: independent AW/W capture, one-deep
// write buffering behind a pending B, registered read path.
module axi4_lite_reg_slave
  import axi4_lite_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned NUM_REGS   = 16
) (
  input  logic                           clk_i,
  input  logic                           rst_n_i,
  input  logic [ADDR_WIDTH-1:0]          s_awaddr,
  input  logic [2:0]                     s_awprot,
  input  logic                           s_awvalid,
  output logic                           s_awready,
  input  logic [DATA_WIDTH-1:0]          s_wdata,
  input  logic [DATA_WIDTH/8-1:0]        s_wstrb,
  input  logic                           s_wvalid,
  output logic                           s_wready,
  output logic [1:0]                     s_bresp,
  output logic                           s_bvalid,
  input  logic                           s_bready,
  input  logic [ADDR_WIDTH-1:0]          s_araddr,
  input  logic [2:0]                     s_arprot,
  input  logic                           s_arvalid,
  output logic                           s_arready,
  output logic [DATA_WIDTH-1:0]          s_rdata,
  output logic [1:0]                     s_rresp,
  output logic                           s_rvalid,
  input  logic                           s_rready,
  output logic [NUM_REGS*DATA_WIDTH-1:0] regs_o
);

  localparam int unsigned STRB_W = DATA_WIDTH / 8;
  localparam int unsigned OFFS   = $clog2(STRB_W);
  localparam int unsigned IDXW   = ADDR_WIDTH - OFFS;
  localparam int unsigned RW     = idx_w(NUM_REGS);

  localparam logic [IDXW-1:0] LIMIT = IDXW'(NUM_REGS);

  logic                  aw_held_q, aw_held_d;
  logic [ADDR_WIDTH-1:0] awaddr_q, awaddr_d;
  logic                  w_held_q, w_held_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [STRB_W-1:0]     wstrb_q, wstrb_d;
  logic                  bvalid_q, bvalid_d;
  axi_resp_t             bresp_q, bresp_d;
  logic                  rvalid_q, rvalid_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  axi_resp_t             rresp_q, rresp_d;

  logic                  aw_hs, w_hs, ar_hs;
  logic                  commit, aw_ok, ar_ok;
  logic [DATA_WIDTH-1:0] arr_rdata;
  logic                  unused_ok;

  assign s_awready = ~aw_held_q;
  assign s_wready  = ~w_held_q;
  assign s_arready = ~rvalid_q;

  assign aw_hs  = s_awvalid & s_awready;
  assign w_hs   = s_wvalid & s_wready;
  assign ar_hs  = s_arvalid & s_arready;
  assign commit = aw_held_q & w_held_q & ~bvalid_q;

  assign aw_ok = awaddr_q[ADDR_WIDTH-1:OFFS] < LIMIT;
  assign ar_ok = s_araddr[ADDR_WIDTH-1:OFFS] < LIMIT;

  assign unused_ok = ^{s_awprot, s_arprot,
                       s_araddr[OFFS-1:0],
                       awaddr_q[OFFS-1:0]};

  axi4_lite_reg_array #(
    .DATA_WIDTH (DATA_WIDTH),
    .NUM_REGS   (NUM_REGS),
    .RW         (RW)
  ) u_array (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .we_i    (commit & aw_ok),
    .waddr_i (awaddr_q[OFFS +: RW]),
    .wdata_i (wdata_q),
    .wstrb_i (wstrb_q),
    .raddr_i (s_araddr[OFFS +: RW]),
    .rdata_o (arr_rdata),
    .regs_o  (regs_o)
  );

  // Write side: capture AW/W, commit when both held and B is free.
  always_comb begin
    aw_held_d = aw_held_q;
    awaddr_d  = awaddr_q;
    w_held_d  = w_held_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    bvalid_d  = bvalid_q;
    bresp_d   = bresp_q;
    if (commit) begin
      aw_held_d = 1'b0;
      w_held_d  = 1'b0;
      bvalid_d  = 1'b1;
      bresp_d   = aw_ok ? AXI_RESP_OKAY : AXI_RESP_SLVERR;
    end else if (bvalid_q && s_bready) begin
      bvalid_d = 1'b0;
    end
    if (aw_hs) begin
      aw_held_d = 1'b1;
      awaddr_d  = s_awaddr;
    end
    if (w_hs) begin
      w_held_d = 1'b1;
      wdata_d  = s_wdata;
      wstrb_d  = s_wstrb;
    end
  end

  // Read side: sample the array on AR, hold until R handshake.
  always_comb begin
    rvalid_d = rvalid_q;
    rdata_d  = rdata_q;
    rresp_d  = rresp_q;
    if (ar_hs) begin
      rvalid_d = 1'b1;
      rdata_d  = ar_ok ? arr_rdata : '0;
      rresp_d  = ar_ok ? AXI_RESP_OKAY : AXI_RESP_SLVERR;
    end else if (rvalid_q && s_rready) begin
      rvalid_d = 1'b0;
    end
  end

  // Channel state flops; reset abandons anything in flight.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      aw_held_q <= 1'b0;
      awaddr_q  <= '0;
      w_held_q  <= 1'b0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      bvalid_q  <= 1'b0;
      bresp_q   <= AXI_RESP_OKAY;
      rvalid_q  <= 1'b0;
      rdata_q   <= '0;
      rresp_q   <= AXI_RESP_OKAY;
    end else begin
      aw_held_q <= aw_held_d;
      awaddr_q  <= awaddr_d;
      w_held_q  <= w_held_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
      bvalid_q  <= bvalid_d;
      bresp_q   <= bresp_d;
      rvalid_q  <= rvalid_d;
      rdata_q   <= rdata_d;
      rresp_q   <= rresp_d;
    end
  end

  assign s_bvalid = bvalid_q;
  assign s_bresp  = bresp_q;
  assign s_rvalid = rvalid_q;
  assign s_rdata  = rdata_q;
  assign s_rresp  = rresp_q;

endmodule

// File: tb/tb_axi4_lite_reg_slave.sv
// Directed bench for the AXI4-Lite CSR slave.
// Expected values are hand-computed per step.
module tb_axi4_lite_reg_slave;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int NR = 16;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [AW-1:0] awaddr, araddr;
  logic [2:0]    awprot, arprot;
  logic          awvalid, awready;
  logic [DW-1:0] wdata;
  logic [3:0]    wstrb;
  logic          wvalid, wready;
  logic [1:0]    bresp, rresp;
  logic          bvalid, bready;
  logic          arvalid, arready;
  logic [DW-1:0] rdata;
  logic          rvalid, rready;
  logic [NR*DW-1:0] regs;

  int nvec = 0;
  int nfail = 0;
  logic [31:0] exp_r [NR];
  logic [31:0] d;
  logic [1:0]  r;

  always #5 clk = ~clk;

  axi4_lite_reg_slave #(
    .ADDR_WIDTH (AW),
    .DATA_WIDTH (DW),
    .NUM_REGS   (NR)
  ) dut (
    .clk_i     (clk),
    .rst_n_i   (rst_n),
    .s_awaddr  (awaddr),
    .s_awprot  (awprot),
    .s_awvalid (awvalid),
    .s_awready (awready),
    .s_wdata   (wdata),
    .s_wstrb   (wstrb),
    .s_wvalid  (wvalid),
    .s_wready  (wready),
    .s_bresp   (bresp),
    .s_bvalid  (bvalid),
    .s_bready  (bready),
    .s_araddr  (araddr),
    .s_arprot  (arprot),
    .s_arvalid (arvalid),
    .s_arready (arready),
    .s_rdata   (rdata),
    .s_rresp   (rresp),
    .s_rvalid  (rvalid),
    .s_rready  (rready),
    .regs_o    (regs)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] reg_of(input int k);
    return regs[k*DW +: DW];
  endfunction

  task automatic chk_regs(input string tag);
    for (int k = 0; k < NR; k++) begin
      chk($sformatf("%s_r%0d", tag, k), reg_of(k), exp_r[k]);
    end
  endtask

  task automatic do_write(input logic [31:0] a,
                          input logic [31:0] dat,
                          input logic [3:0] st,
                          output logic [1:0] resp);
    logic ah, wh;
    bit   got;
    awaddr = a; wdata = dat; wstrb = st;
    awvalid = 1'b1; wvalid = 1'b1;
    for (int i = 0; i < 20 && (awvalid || wvalid); i++) begin
      ah = awready; wh = wready;
      tick();
      if (ah) awvalid = 1'b0;
      if (wh) wvalid = 1'b0;
    end
    chk("wr_accept_tmo", {63'd0, awvalid | wvalid}, 64'd0);
    awvalid = 1'b0; wvalid = 1'b0;
    bready = 1'b1;
    got = 1'b0;
    resp = 2'bxx;
    for (int i = 0; i < 20 && !got; i++) begin
      if (bvalid) begin
        resp = bresp;
        got = 1'b1;
      end
      tick();
    end
    chk("b_tmo", {63'd0, got}, 64'd1);
    bready = 1'b0;
  endtask

  task automatic do_read(input logic [31:0] a,
                         output logic [31:0] dat,
                         output logic [1:0] resp);
    bit acc, got;
    araddr = a; arvalid = 1'b1;
    acc = 1'b0;
    for (int i = 0; i < 20 && !acc; i++) begin
      acc = arready;
      tick();
    end
    chk("ar_tmo", {63'd0, acc}, 64'd1);
    arvalid = 1'b0;
    rready = 1'b1;
    got = 1'b0;
    dat = 'x; resp = 'x;
    for (int i = 0; i < 20 && !got; i++) begin
      if (rvalid) begin
        dat = rdata; resp = rresp;
        got = 1'b1;
      end
      tick();
    end
    chk("r_tmo", {63'd0, got}, 64'd1);
    rready = 1'b0;
  endtask

  initial begin
    for (int k = 0; k < NR; k++) exp_r[k] = '0;
    rst_n = 1'b0;
    awaddr = '0; araddr = '0; awprot = '0; arprot = '0;
    awvalid = 0; wvalid = 0; wdata = '0; wstrb = '0;
    bready = 0; arvalid = 0; rready = 0;
    repeat (3) tick();

    // reset state
    chk("rst_bvalid", bvalid, 0);
    chk("rst_rvalid", rvalid, 0);
    chk("rst_rdata", rdata, 0);
    chk("rst_awready", awready, 1);
    chk("rst_wready", wready, 1);
    chk("rst_arready", arready, 1);
    chk_regs("rst");
    rst_n = 1'b1;
    tick();

    // reg 3: AW+W in same cycle, B two edges later
    awaddr = 32'h0C; wdata = 32'hDEADBEEF; wstrb = 4'hF;
    awvalid = 1; wvalid = 1;
    tick();
    awvalid = 0; wvalid = 0;
    chk("w1_awready_held", awready, 0);
    chk("w1_wready_held", wready, 0);
    chk("w1_bvalid_early", bvalid, 0);
    tick();
    chk("w1_bvalid", bvalid, 1);
    chk("w1_bresp", bresp, 0);
    chk("w1_awready_free", awready, 1);
    exp_r[3] = 32'hDEADBEEF;
    chk("w1_reg3", reg_of(3), exp_r[3]);
    bready = 1;
    tick();
    bready = 0;
    chk("w1_bvalid_clr", bvalid, 0);

    do_read(32'h0C, d, r);
    chk("r3_data", d, 32'hDEADBEEF);
    chk("r3_resp", r, 0);

    // byte strobes 0x5
    do_write(32'h0C, 32'h11223344, 4'h5, r);
    chk("ws_resp", r, 0);
    exp_r[3] = 32'hDE22BE44;
    do_read(32'h0C, d, r);
    chk("ws_data", d, 32'hDE22BE44);
    // low offset bits ignored
    do_read(32'h0E, d, r);
    chk("off_data", d, 32'hDE22BE44);
    chk("off_resp", r, 0);

    // W three cycles before AW
    wdata = 32'h1; wstrb = 4'hF; wvalid = 1;
    tick();
    wvalid = 0;
    chk("wf_wready0", wready, 0);
    tick(); tick();
    chk("wf_wready_hold", wready, 0);
    chk("wf_bvalid0", bvalid, 0);
    chk("wf_reg1_old", reg_of(1), 0);
    awaddr = 32'h04; awvalid = 1;
    tick();
    awvalid = 0;
    chk("wf_bvalid_pre", bvalid, 0);
    tick();
    chk("wf_bvalid", bvalid, 1);
    chk("wf_wready_free", wready, 1);
    exp_r[1] = 32'h1;
    chk("wf_reg1", reg_of(1), exp_r[1]);
    bready = 1;
    tick();
    bready = 0;
    repeat (2) tick();
    chk("wf_single_b", bvalid, 0);

    // last register and out of range
    do_write(32'h3C, 32'h0BADF00D, 4'hF, r);
    chk("last_resp", r, 0);
    exp_r[15] = 32'h0BADF00D;
    do_write(32'h40, 32'hFFFFFFFF, 4'hF, r);
    chk("oor_bresp", r, 2'b10);
    chk_regs("oor");
    do_read(32'h40, d, r);
    chk("oor_rresp", r, 2'b10);
    chk("oor_rdata", d, 0);

    // B backpressure with a second write queued
    awaddr = 32'h08; wdata = 32'hAAAA5555; wstrb = 4'hF;
    awvalid = 1; wvalid = 1;
    tick();
    awvalid = 0; wvalid = 0;
    tick();
    exp_r[2] = 32'hAAAA5555;
    chk("bp_bvalid", bvalid, 1);
    repeat (5) tick();
    chk("bp_bvalid_hold", bvalid, 1);
    chk("bp_bresp_hold", bresp, 0);
    chk("bp_awready", awready, 1);
    awaddr = 32'h10; wdata = 32'h12345678;
    awvalid = 1; wvalid = 1;
    tick();
    awvalid = 0; wvalid = 0;
    chk("bp2_awready", awready, 0);
    chk("bp2_wready", wready, 0);
    tick(); tick();
    chk("bp2_deferred", reg_of(4), 0);
    bready = 1;
    tick();
    chk("bp2_b1_clr", bvalid, 0);
    tick();
    exp_r[4] = 32'h12345678;
    chk("bp2_b2", bvalid, 1);
    chk("bp2_reg4", reg_of(4), exp_r[4]);
    tick();
    bready = 0;
    chk("bp2_b2_clr", bvalid, 0);

    // R backpressure
    araddr = 32'h08; arvalid = 1;
    tick();
    arvalid = 0;
    chk("rp_rvalid", rvalid, 1);
    chk("rp_rdata", rdata, 32'hAAAA5555);
    araddr = 32'h10; arvalid = 1;
    repeat (3) tick();
    chk("rp_arready", arready, 0);
    chk("rp_rdata_hold", rdata, 32'hAAAA5555);
    rready = 1;
    tick();
    rready = 0;
    chk("rp_rvalid_clr", rvalid, 0);
    tick();
    arvalid = 0;
    chk("rp2_rdata", rdata, 32'h12345678);
    rready = 1;
    tick();
    rready = 0;

    // read and commit to reg 4 on the same edge
    awaddr = 32'h10; wdata = 32'hCAFEF00D; wstrb = 4'hF;
    awvalid = 1; wvalid = 1;
    tick();
    awvalid = 0; wvalid = 0;
    araddr = 32'h10; arvalid = 1;
    tick();
    arvalid = 0;
    exp_r[4] = 32'hCAFEF00D;
    chk("rw_old_data", rdata, 32'h12345678);
    chk("rw_bvalid", bvalid, 1);
    chk("rw_reg4", reg_of(4), exp_r[4]);
    bready = 1; rready = 1;
    tick();
    bready = 0; rready = 0;
    chk_regs("pre_rst");

    // async reset with B pending and AW held
    awaddr = 32'h14; wdata = 32'h55; awvalid = 1; wvalid = 1;
    tick();
    awvalid = 0; wvalid = 0;
    tick();
    chk("ar_bpend", bvalid, 1);
    awaddr = 32'h18; awvalid = 1;
    tick();
    awvalid = 0;
    chk("ar_awheld", awready, 0);
    #2;
    rst_n = 1'b0;
    #1;
    for (int k = 0; k < NR; k++) exp_r[k] = '0;
    chk("ar_bvalid", bvalid, 0);
    chk("ar_awready", awready, 1);
    chk("ar_rdata", rdata, 0);
    chk_regs("ar");
    tick(); tick();
    rst_n = 1'b1;
    wdata = 32'h77; wvalid = 1;
    tick();
    wvalid = 0;
    repeat (3) tick();
    chk("ar_no_stray_b", bvalid, 0);
    chk("ar_regs5", reg_of(5), 0);
    chk("ar_regs6", reg_of(6), 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule

// File: doc/axi4_lite_reg_slave.md
Name: axi4_lite_reg_slave

Overview:
- AXI4-Lite responder (slave end) that terminates one AXI4-Lite port on a bank of NUM_REGS read/write registers.
- Register contents are exported flat to fabric logic.
- Used as the CSR block behind AXI4-Lite masters in the design. Transaction IDs are not used.
- Complements the existing AXI4-Lite master-side logic.

Parameters:
- ADDR_WIDTH, 32, byte-address width of awaddr/araddr.
- DATA_WIDTH, 32, data width; must be 32 or 64.
- NUM_REGS, 16, number of registers; must be ≥1.

Ports:
- clk_i  in  1  clock
- rst_n_i  in  1  asynchronous active-low reset
- s_awaddr  in  ADDR_WIDTH  write address
- s_awprot  in  3  protection (ignored)
- s_awvalid  in  1  write address valid
- s_awready  out  1  write address ready
- s_wdata  in  DATA_WIDTH  write data
- s_wstrb  in  DATA_WIDTH/8  byte strobes
- s_wvalid  in  1  write data valid
- s_wready  out  1  write data ready
- s_bresp  out  2  write response
- s_bvalid  out  1  write response valid
- s_bready  in  1  write response ready
- s_araddr  in  ADDR_WIDTH  read address
- s_arprot  in  3  protection (ignored)
- s_arvalid  in  1  read address valid
- s_arready  out  1  read address ready
- s_rdata  out  DATA_WIDTH  read data
- s_rresp  out  2  read response
- s_rvalid  out  1  read data valid
- s_rready  in  1  read data ready
- regs_o  out  NUM_REGS*DATA_WIDTH  register contents; register k at bits [k*DATA_WIDTH +: DATA_WIDTH]

Behaviour:
- Reset (rst_n_i low, asynchronous):
  - All registers, s_bvalid, s_rvalid, s_rdata, s_bresp and s_rresp clear to 0.
  - The AW-held and W-held flags clear.
- Address decode:
  - Word index = addr[ADDR_WIDTH-1 : log2(DATA_WIDTH/8)]; low byte-offset bits are ignored.
  - Index < NUM_REGS → OKAY (2'b00); otherwise SLVERR (2'b10).
- AW channel:
  - s_awready = ~aw_held.
  - On awvalid&awready, latch the address and set aw_held.
- W channel:
  - s_wready = ~w_held.
  - On wvalid&wready, latch data and strobes and set w_held.
  - AW and W are accepted independently, in either order or in the same cycle.
- Write commit occurs in the cycle when aw_held & w_held & ~s_bvalid:
  - On OKAY, bytes with strobe=1 are updated; bytes with strobe=0 keep their value.
  - On SLVERR, no register changes.
  - aw_held and w_held clear, s_bvalid=1 and s_bresp=decode result, all registered (visible next cycle).
- B channel:
  - s_bvalid and s_bresp hold stable until s_bready.
  - s_bvalid clears on the handshake edge.
- Minimum write latency: W/AW handshake at edge N → commit at N+1 → s_bvalid high after N+1.
  - A new AW/W may be accepted while B is pending (one deep); commit waits for B to drain.
- Read:
  - s_arready = ~s_rvalid.
  - On arvalid&arready, s_rdata = register value (0 on SLVERR), s_rresp = decode result, s_rvalid=1 next cycle.
  - Read data is held stable until s_rready; s_rvalid clears on the handshake edge.
  - Back-to-back reads are therefore one per 2 cycles.
- Simultaneous read handshake and write commit to the same register: the read returns the pre-write value.
- regs_o reflects register state combinationally from the flops (updates one cycle after commit).
- Reset mid-transaction abandons all held/pending state; no response is issued for it.

Decomposition:
- Add AXI_RESP_OKAY=2'b00 and AXI_RESP_SLVERR=2'b10 constants to axi4_lite_pkg, alongside the existing axi_resp_t/axi_prot_t.
- A register-array sub-module is natural: axi4_lite_reg_array (byte-strobed write port, combinational read port, flat output).
- Channel logic stays in the top level.

Test Plan:
- Write to reg 3: AW 0x0C and W 0xDEADBEEF with strobe 0xF in the same cycle → s_bvalid 2 cycles later, bresp 0; read 0x0C → rdata 0xDEADBEEF, rresp 0; regs_o[3] = 0xDEADBEEF.
- Byte strobes: reg 3 = 0xDEADBEEF, write 0x11223344 with strobe 0x5 → read 0xDE22BE44.
- W three cycles before AW (address 0x04, data 0x1): s_wready low after W accepted until commit; single B response; reg 1 = 0x1.
- Out-of-range access: address 0x40 with NUM_REGS=16 → write bresp 2'b10, no register changes; read rresp 2'b10, rdata 0.
- Backpressure: hold s_bready=0 for 5 cycles after a write, then issue a second AW+W → both accepted, second commit deferred until B handshake; then second bvalid follows; same with s_rready=0 → s_arready low, rdata stable.
- Async reset asserted while B pending and aw_held set → all outputs 0, regs 0 immediately, no stray bvalid after release.
